// File: rtl/ws2811_frame_scheduler_if.sv
// ws2811_frame_scheduler_if: host write port, swap control and driver read port of the frame scheduler
//   master (host/driver side): drives wr_valid/wr_addr/wr_rgb, swap_req, brightness, drv_data_request/drv_address
//   slave (scheduler side): drives wr_ready, swap_ack, red_out/green_out/blue_out, frame_start, frame_count
interface ws2811_frame_scheduler_if #(parameter int ADDR_W = 2);
  logic              wr_valid;
  logic              wr_ready;
  logic [ADDR_W-1:0] wr_addr;
  logic [23:0]       wr_rgb;
  logic              swap_req;
  logic              swap_ack;
  logic [7:0]        brightness;
  logic              drv_data_request;
  logic [ADDR_W-1:0] drv_address;
  logic [7:0]        red_out;
  logic [7:0]        green_out;
  logic [7:0]        blue_out;
  logic              frame_start;
  logic [15:0]       frame_count;
  modport master (
    output wr_valid, wr_addr, wr_rgb, swap_req, brightness, drv_data_request, drv_address,
    input  wr_ready, swap_ack, red_out, green_out, blue_out, frame_start, frame_count
  );
  modport slave (
    input  wr_valid, wr_addr, wr_rgb, swap_req, brightness, drv_data_request, drv_address,
    output wr_ready, swap_ack, red_out, green_out, blue_out, frame_start, frame_count
  );
endinterface

// File: rtl/ws2811_frame_scheduler.sv
// ws2811_frame_scheduler: double-buffered pixel store with tear-free bank swaps and brightness-scaled reads for the ws2811 driver
//   clk   : clock
//   reset : synchronous, active-high reset
//   bus   : slave side of ws2811_frame_scheduler_if (host writes to back bank, driver reads front bank)
module ws2811_frame_scheduler #(
  parameter int NUM_LEDS = 4,
  parameter int ADDR_W   = (NUM_LEDS > 1) ? $clog2(NUM_LEDS) : 1
) (
  input logic clk,
  input logic reset,
  ws2811_frame_scheduler_if.slave bus
);
  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_PEND = 1'b1;
  localparam logic [ADDR_W:0] LEDS = (ADDR_W+1)'(NUM_LEDS);
  // Bank is the top address bit; entries at or beyond NUM_LEDS are never written or read.
  logic [23:0] r_mem [2**(ADDR_W+1)];
  logic [0:0]  r_state;
  logic        r_front;
  logic [7:0]  r_bright;
  logic        r_fs;
  logic        r_ack;
  logic [15:0] r_cnt;
  logic [23:0] r_rgb;
  logic        w_fs;
  logic        w_swap;
  logic        w_front;
  logic [7:0]  w_bright;
  logic [23:0] w_pix;
  logic        w_rd_ok;
  logic        w_wr;
  function automatic logic [7:0] scale(input logic [7:0] c, input logic [7:0] b);
    logic [15:0] p;
    p = {8'd0, c} * ({8'd0, b} + 16'd1);
    return p[15:8];
  endfunction
  // Bank select and brightness take effect in the request cycle so LED 0 of a new frame already sees them.
  always_comb begin
    w_fs     = bus.drv_data_request && (bus.drv_address == '0);
    w_swap   = w_fs && (r_state == S_PEND);
    w_front  = r_front ^ w_swap;
    w_bright = w_fs ? bus.brightness : r_bright;
    w_pix    = r_mem[{w_front, bus.drv_address}];
    w_rd_ok  = {1'b0, bus.drv_address} < LEDS;
    w_wr     = bus.wr_valid && (r_state == S_IDLE) && ({1'b0, bus.wr_addr} < LEDS);
  end
  always_ff @(posedge clk) begin
    if (w_wr) r_mem[{~r_front, bus.wr_addr}] <= bus.wr_rgb;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state  <= S_IDLE;
      r_front  <= 1'b0;
      r_bright <= 8'hFF;
      r_fs     <= 1'b0;
      r_ack    <= 1'b0;
      r_cnt    <= 16'd0;
      r_rgb    <= 24'd0;
    end else begin
      r_state  <= w_swap ? S_IDLE : ((r_state == S_IDLE) && bus.swap_req) ? S_PEND : r_state;
      r_front  <= w_front;
      r_bright <= w_bright;
      r_fs     <= w_fs;
      r_ack    <= w_swap;
      r_cnt    <= w_fs ? r_cnt + 16'd1 : r_cnt;
      if (bus.drv_data_request)
        r_rgb <= w_rd_ok ? {scale(w_pix[23:16], w_bright), scale(w_pix[15:8], w_bright), scale(w_pix[7:0], w_bright)} : 24'd0;
    end
  end
  assign bus.wr_ready    = (r_state == S_IDLE);
  assign bus.swap_ack    = r_ack;
  assign bus.frame_start = r_fs;
  assign bus.frame_count = r_cnt;
  assign bus.red_out     = r_rgb[23:16];
  assign bus.green_out   = r_rgb[15:8];
  assign bus.blue_out    = r_rgb[7:0];
endmodule

// File: tb/tb_ws2811_frame_scheduler.sv
// tb_ws2811_frame_scheduler: directed scenarios plus random traffic checked against a transaction-level model
module tb_ws2811_frame_scheduler;
  localparam int N  = 4;
  localparam int AW = 3;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int n_vec = 0;
  int n_err = 0;
  logic [23:0] m_mem [2][N];
  bit          m_front;
  bit          m_pend;
  logic [7:0]  m_bright;
  logic [15:0] m_cnt;
  logic [23:0] m_rgb;
  bit          m_fs;
  bit          m_ack;
  always #5 clk = ~clk;
  ws2811_frame_scheduler_if #(.ADDR_W(AW)) bus();
  ws2811_frame_scheduler #(.NUM_LEDS(N), .ADDR_W(AW)) dut (.clk(clk), .reset(reset), .bus(bus));
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h expected=%h t=%0t", tag, got, exp, $time);
    end
  endtask
  function automatic logic [7:0] sc(input logic [7:0] c, input logic [7:0] b);
    int p;
    p = int'(c) * (int'(b) + 1);
    return 8'(p / 256);
  endfunction
  function automatic logic [23:0] sc_rgb(input logic [23:0] px, input logic [7:0] b);
    return {sc(px[23:16], b), sc(px[15:8], b), sc(px[7:0], b)};
  endfunction
  task automatic clr();
    bus.wr_valid = 0; bus.wr_addr = '0; bus.wr_rgb = '0; bus.swap_req = 0;
    bus.drv_data_request = 0; bus.drv_address = '0;
  endtask
  task automatic model();
    bit fs;
    bit was_pend;
    int a;
    if (reset) begin
      m_pend = 0; m_front = 0; m_bright = 8'hFF; m_cnt = 0; m_rgb = 0; m_fs = 0; m_ack = 0;
      return;
    end
    was_pend = m_pend;
    fs = bus.drv_data_request && bus.drv_address == 0;
    if (bus.wr_valid && !was_pend && int'(bus.wr_addr) < N) m_mem[!m_front][int'(bus.wr_addr)] = bus.wr_rgb;
    m_ack = fs && was_pend;
    if (m_ack) begin m_front = !m_front; m_pend = 0; end
    else if (!was_pend && bus.swap_req) m_pend = 1;
    if (fs) begin m_bright = bus.brightness; m_cnt++; end
    m_fs = fs;
    a = int'(bus.drv_address);
    if (bus.drv_data_request) m_rgb = (a < N) ? sc_rgb(m_mem[m_front][a], m_bright) : 24'd0;
  endtask
  task automatic step();
    @(posedge clk);
    model();
    #1;
    chk("wr_ready", 32'(bus.wr_ready), 32'(!m_pend));
    chk("swap_ack", 32'(bus.swap_ack), 32'(m_ack));
    chk("frame_start", 32'(bus.frame_start), 32'(m_fs));
    chk("frame_count", 32'(bus.frame_count), 32'(m_cnt));
    chk("rgb", {8'd0, bus.red_out, bus.green_out, bus.blue_out}, {8'd0, m_rgb});
  endtask
  task automatic wr(input int a, input logic [23:0] v);
    clr(); bus.wr_valid = 1; bus.wr_addr = AW'(a); bus.wr_rgb = v; step();
  endtask
  task automatic req(input int a);
    clr(); bus.drv_data_request = 1; bus.drv_address = AW'(a); step();
  endtask
  task automatic swap();
    clr(); bus.swap_req = 1; step(); req(0);
  endtask
  function automatic logic [31:0] rgb_now();
    return {8'd0, bus.red_out, bus.green_out, bus.blue_out};
  endfunction
  initial begin
    clr();
    bus.brightness = 8'hFF;
    step(); step();
    reset = 0;
    for (int a = 0; a < N; a++) wr(a, 24'd0);
    swap();
    for (int a = 0; a < N; a++) wr(a, 24'd0);
    swap();
    reset = 1; clr(); step(); reset = 0;
    chk("rst_count", 32'(bus.frame_count), 32'd0);
    req(0);
    chk("t1_fs", 32'(bus.frame_start), 32'd1);
    chk("t1_count", 32'(bus.frame_count), 32'd1);
    chk("t1_rgb", rgb_now(), 32'd0);
    wr(1, 24'h102030);
    clr(); bus.swap_req = 1; step();
    req(0);
    chk("t2_ack", 32'(bus.swap_ack), 32'd1);
    req(1);
    chk("t2_rgb", rgb_now(), 32'h102030);
    wr(2, 24'hFF8001);
    clr(); bus.swap_req = 1; step();
    bus.brightness = 8'h7F;
    req(0);
    req(2);
    chk("t3_rgb", rgb_now(), 32'h7F4000);
    bus.brightness = 8'h00;
    req(2);
    chk("t3_midframe", rgb_now(), 32'h7F4000);
    clr(); bus.swap_req = 1; step();
    chk("t4_ready_low", 32'(bus.wr_ready), 32'd0);
    wr(3, 24'hABCDEF);
    bus.brightness = 8'hFF;
    clr(); bus.wr_valid = 1; bus.wr_addr = 3; bus.wr_rgb = 24'hABCDEF; bus.drv_data_request = 1; step();
    chk("t4_ack", 32'(bus.swap_ack), 32'd1);
    wr(3, 24'hABCDEF);
    chk("t4_ready_high", 32'(bus.wr_ready), 32'd1);
    swap();
    req(3);
    chk("t4_landed", rgb_now(), 32'hABCDEF);
    clr(); bus.swap_req = 1; bus.drv_data_request = 1; step();
    chk("t5_no_ack", 32'(bus.swap_ack), 32'd0);
    req(1);
    req(0);
    chk("t5_ack_next", 32'(bus.swap_ack), 32'd1);
    req(N);
    chk("t6_oor_rgb", rgb_now(), 32'd0);
    wr(N + 1, 24'h123456);
    clr(); bus.swap_req = 1; step();
    req(1);
    reset = 1; clr(); step(); reset = 0;
    chk("t6_rst_rgb", rgb_now(), 32'd0);
    chk("t6_rst_ready", 32'(bus.wr_ready), 32'd1);
    req(0);
    chk("t6_no_ack", 32'(bus.swap_ack), 32'd0);
    for (int i = 0; i < 600; i++) begin
      reset = ($urandom_range(0, 79) == 0);
      bus.wr_valid = $urandom_range(0, 1) == 1;
      bus.wr_addr = AW'($urandom_range(0, 2**AW - 1));
      bus.wr_rgb = 24'($urandom);
      bus.swap_req = $urandom_range(0, 7) == 0;
      bus.brightness = 8'($urandom);
      bus.drv_data_request = $urandom_range(0, 4) < 3;
      bus.drv_address = ($urandom_range(0, 3) == 0) ? '0 : AW'($urandom_range(0, 2**AW - 1));
      step();
    end
    reset = 0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
